fp_add_arbiter: RTL and testbench

Shares one combinational fp_add unit (32-bit IEEE-754 single-precision adder) between NUM_REQ requesters.
- Picks a requester round-robin and registers its two operands into the adder inputs.
- Captures the adder result and returns it with the requester ID over a valid/ready response channel.
- fp_add is instantiated in the parent and wired to the add_* ports, so this block owns only sequencing and arbitration.

---
 rtl/fp_add_arb_pkg.sv | 15 +
 rtl/fp_add_arbiter_rr.sv | 41 ++++
 rtl/fp_add_arbiter.sv | 145 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_arb_pkg.sv
// Shared definitions for the fp_add arbiter slice.
// Holds the floating-point word geometry and the sequencing FSM encoding
// used by fp_add_arbiter.
package fp_add_arb_pkg;

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fp_add_arbiter_rr.sv
// Purely combinational round-robin grant logic.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the requester served last; search starts just above it
//   grant - one-hot grant (all zero when no request is present)
//   index - binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  // Requests strictly above the pointer take priority; if none exist the
  // search wraps around to the lowest asserted request overall.
  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = (ID_W'(i) > ptr);
    end
    pick  = ((req & upper) != '0) ? (req & upper) : req;
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i] && !found) begin
        grant[i] = 1'b1;
        index    = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one combinational fp_add unit between NUM_REQ requesters.
// A requester is chosen round-robin, its operands are registered onto the
// add_* ports, the adder result is captured one cycle later and returned
// with the requester index over a valid/ready response channel.
// Optional build macro FP_ADD_ARB_SUB_EN adds req_sub: when set for the
// accepted requester, operand B is latched with its sign flipped (A-B).
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   req_valid/req_ready - per-requester request handshake (ready one-hot)
//   req_a, req_b        - packed operands, requester i at [32*i +: 32]
//   req_sub             - per-requester subtract select (macro only)
//   add_a, add_b        - registered operands to the external adder
//   add_result          - combinational sum from the external adder
//   rsp_valid/rsp_ready - response handshake
//   rsp_data, rsp_id    - registered sum and owning requester index
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
`ifdef FP_ADD_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]      req_sub,
`endif
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  input  logic [FP_W-1:0]         add_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id
);

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic [FP_W-1:0]    sel_a;
  logic [FP_W-1:0]    sel_b;
  logic [FP_W-1:0]    b_lat;
`ifdef FP_ADD_ARB_SUB_EN
  logic               sel_sub;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .index (grant_idx)
  );

  // The grant only ever contains asserted requests, so gating it with IDLE
  // gives a ready that implies a transfer in the same cycle.
  assign accept    = (state == IDLE) && (req_valid != '0);
  assign req_ready = (state == IDLE) ? grant : '0;

  // Operand mux driven by the one-hot grant; the sign flip for subtraction
  // is applied to every operand class alike, NaN and zero included.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
`ifdef FP_ADD_ARB_SUB_EN
    sel_sub = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
`ifdef FP_ADD_ARB_SUB_EN
        sel_sub = req_sub[i];
`endif
      end
    end
`ifdef FP_ADD_ARB_SUB_EN
    b_lat = sel_sub ? {~sel_b[FP_SIGN_BIT], sel_b[FP_SIGN_BIT-1:0]} : sel_b;
`else
    b_lat = sel_b;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept, give the adder one cycle, then hold the
  // response until the consumer takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers. add_a/add_b are only reloaded on acceptance so the
  // adder output stays stable while a response is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a     <= '0;
      add_b     <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            add_a  <= sel_a;
            add_b  <= b_lat;
            rsp_id <= grant_idx;
            rr_ptr <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data  <= add_result;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter.
// The external adder is modelled here with exact fixed-point arithmetic on
// operands that are multiples of 1/256. A stimulus process drives requests
// and predicts the round-robin grant; on each predicted acceptance it queues
// the expected response. A monitor process compares every presented
// response against the queue head and checks response timing.
// Build with FP_ADD_ARB_SUB_EN defined to exercise the subtract option.
module tb_fp_add_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
`ifdef FP_ADD_ARB_SUB_EN
  logic [N-1:0]    req_sub;
`endif
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [ID_W-1:0] rsp_id;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  exp_t        sb_q[$];
  bit          model_busy = 0;
  int          model_ptr  = N - 1;
  int          accept_cycle = 0;
  bit          pending[N];
  logic [31:0] op_a[N];
  logic [31:0] op_b[N];
  bit          op_sub[N];
  logic [31:0] op_sum[N];

  fp_add_arbiter #(
    .NUM_REQ (N),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef FP_ADD_ARB_SUB_EN
    .req_sub    (req_sub),
`endif
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Float -> value*256 (exact for the operand range used here).
  function automatic longint f2fix(logic [31:0] f);
    longint m;
    int     e;
    if (f[30:23] == 8'd0) return 0;
    m = {40'd0, 1'b1, f[22:0]};
    e = int'(f[30:23]) - 127 - 15;
    if (e >= 0) m = m << e;
    else        m = m >> (-e);
    return f[31] ? -m : m;
  endfunction

  // value*256 -> float (exact while magnitude fits in 24 significant bits).
  function automatic logic [31:0] fix2f(longint s);
    logic        sign;
    logic [63:0] mag;
    logic [63:0] norm;
    int          p;
    if (s == 0) return 32'h0;
    sign = (s < 0);
    mag  = sign ? 64'(-s) : 64'(s);
    p = 0;
    for (int k = 0; k < 63; k++) if (mag[k]) p = k;
    if (p >= 23) norm = mag >> (p - 23);
    else         norm = mag << (23 - p);
    return {sign, 8'(p - 8 + 127), norm[22:0]};
  endfunction

  // Behavioural stand-in for the combinational fp_add unit.
  always_comb add_result = fix2f(f2fix(add_a) + f2fix(add_b));

  // Round-robin rule: first valid requester above the last one served.
  function automatic int model_grant(logic [N-1:0] v, int ptr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_value(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic load_op(int id, logic [31:0] a, logic [31:0] b, bit sub, logic [31:0] sum);
    op_a[id]    = a;
    op_b[id]    = b;
    op_sub[id]  = sub;
    op_sum[id]  = sum;
    pending[id] = 1'b1;
  endtask

  task automatic load_random(int id);
    longint sa, sb;
    bit     sub;
    sa  = longint'($urandom_range(0, 1048576)) - 524288;
    sb  = longint'($urandom_range(0, 1048576)) - 524288;
`ifdef FP_ADD_ARB_SUB_EN
    sub = $urandom_range(0, 1) == 1;
`else
    sub = 1'b0;
`endif
    load_op(id, fix2f(sa), fix2f(sb), sub, fix2f(sub ? sa - sb : sa + sb));
  endtask

  // Predict the grant for the inputs just driven and compare req_ready.
  task automatic check_output();
    int          g;
    logic [31:0] exp_ready;
    exp_t        e;
    g = model_busy ? -1 : model_grant(req_valid, model_ptr);
    exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
    check_value("req_ready", {28'd0, req_ready}, exp_ready);
    if (g >= 0) begin
      e.id   = g;
      e.a    = op_a[g];
      e.b    = op_sub[g] ? {~op_b[g][31], op_b[g][30:0]} : op_b[g];
      e.data = op_sum[g];
      sb_q.push_back(e);
      pending[g]   = 1'b0;
      model_ptr    = g;
      model_busy   = 1'b1;
      accept_cycle = cycle;
    end
  endtask

  task automatic apply_stimulus(logic [N-1:0] mask, bit ready);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pending[i] & mask[i];
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
`ifdef FP_ADD_ARB_SUB_EN
      req_sub[i]       = op_sub[i];
`endif
    end
    rsp_ready = ready;
    #1;
    check_output();
  endtask

  task automatic drain(int max_cycles);
    int n;
    n = 0;
    while ((model_busy || sb_q.size() != 0 || pending[0] || pending[1] ||
            pending[2] || pending[3]) && n < max_cycles) begin
      apply_stimulus('1, 1'b1);
      n++;
    end
    if (n >= max_cycles) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    sb_q.delete();
    model_busy = 1'b0;
    model_ptr  = N - 1;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    @(negedge clk);
    #1;
    check_value("rst_add_a", add_a, 32'h0);
    check_value("rst_add_b", add_b, 32'h0);
    check_value("rst_rsp_data", rsp_data, 32'h0);
    check_value("rst_rsp_id", {30'd0, rsp_id}, 32'h0);
    check_value("rst_req_ready", {28'd0, req_ready}, 32'h0);
    rst = 1'b0;
  endtask

  // Monitor: response timing, contents and stability against the queue head.
  always @(negedge clk) begin
    bit exp_valid;
    #2;
    exp_valid = model_busy && (cycle - accept_cycle >= 2);
    check_value("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected: got id %0d data %h expected none", rsp_id, rsp_data);
      end else begin
        check_value("rsp_data", rsp_data, sb_q[0].data);
        check_value("rsp_id", {30'd0, rsp_id}, 32'(sb_q[0].id));
        check_value("add_a", add_a, sb_q[0].a);
        check_value("add_b", add_b, sb_q[0].b);
        if (rsp_ready) begin
          void'(sb_q.pop_front());
          model_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
`ifdef FP_ADD_ARB_SUB_EN
    req_sub   = '0;
`endif
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0;
      op_a[i]    = '0;
      op_b[i]    = '0;
      op_sub[i]  = 1'b0;
      op_sum[i]  = '0;
    end
    do_reset();

    // Single requester, 1.0 + 1.0.
    load_op(0, 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000);
    drain(20);

    // Backpressure on requester 2; requester 1 arrives while busy.
    load_op(2, 32'h43164000, 32'hc3160000, 1'b0, 32'h3e800000);
    apply_stimulus('1, 1'b0);
    load_op(1, 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000);
    repeat (7) apply_stimulus('1, 1'b0);
    drain(20);

    // Fairness wrap: serve 3, then 0 and 3 together.
    load_op(3, 32'h3f800000, 32'h3fa00000, 1'b0, 32'h40100000);
    drain(20);
    load_op(0, 32'h3f800000, 32'h3fa00000, 1'b0, 32'h40100000);
    load_op(3, 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000);
    drain(20);

    // All four together from pointer 3: order 0,1,2,3.
    for (int i = 0; i < N; i++) load_op(i, 32'h3f800000, 32'h3fa00000, 1'b0, 32'h40100000);
    drain(40);

`ifdef FP_ADD_ARB_SUB_EN
    load_op(1, 32'h3f800000, 32'h3fa00000, 1'b1, 32'hbe800000);
    drain(20);
`endif

    // Reset during EXEC: the in-flight operation vanishes.
    load_op(0, 32'h3f800000, 32'hbf800000, 1'b0, 32'h00000000);
    apply_stimulus('1, 1'b1);
    do_reset();
    repeat (4) apply_stimulus('1, 1'b1);
    load_op(0, 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000);
    load_op(1, 32'h3f800000, 32'h3fa00000, 1'b0, 32'h40100000);
    drain(20);

    // Randomised traffic with dropping valids and random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) load_random(i);
      end
      apply_stimulus(N'($urandom), $urandom_range(0, 3) != 0);
    end
    drain(200);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
